// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared widths, FSM state encoding and buffer depth for mem_stream_reader.
// Revision 1.0
`default_nettype none

package mem_rd_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam int BUF_DEPTH = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rd_buf2.sv
// rd_buf2: two-entry synchronous FIFO of {last, data}; push and pop may coincide when full.
// Revision 1.0
`default_nettype none

module rd_buf2
  import mem_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last
);

  logic [DATA_W-1:0] data_q [BUF_DEPTH];
  logic              last_q [BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A full buffer can still accept a word if the head leaves in the same cycle.
  assign do_push = push && ((count < 2'(BUF_DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      if (do_push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_last = last_q[rd_ptr] && (count != 2'd0);

endmodule

`default_nettype wire

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: sweeps a window of a 1-cycle-latency block memory and streams it out valid/ready.
// Revision 1.0
`default_nettype none

module mem_stream_reader
  import mem_rd_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [ADDR_W:0] remaining;
  logic            pend;
  logic            pend_last;
  logic [1:0]      occ;
  logic            pop;
  logic            issue;
  logic            drained;

  assign mem_we    = 1'b0;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // Words already buffered plus the one in flight must leave room for the next capture.
  assign issue = (state == READ) && (remaining != '0) &&
                 (({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

  assign drained = !pend && ((occ == 2'd0) || ((occ == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      remaining <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && (remaining == REM_ONE);
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              mem_addr  <= start_addr;
              remaining <= num_words;
              state     <= READ;
            end else begin
              state <= FIN;
            end
          end
        end
        READ: begin
          if (issue) begin
            mem_addr  <= mem_addr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  rd_buf2 #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (pend),
    .push_data (mem_dout),
    .push_last (pend_last),
    .pop       (pop),
    .count     (occ),
    .head_data (out_data),
    .head_last (out_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: randomized bursts against a queue-based model of the expected word stream.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_stream_reader;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   num_words;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= mem[mem_addr];

  mem_stream_reader #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .num_words  (num_words),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: always ready, 1: mostly ready, 2: stalled in cycles 4..6, 3: mostly stalled
  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 2) return !(cyc >= 4 && cyc <= 6);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    if (mode == 3) return ($urandom_range(0, 3) == 0);
    return 1'b1;
  endfunction

  task automatic run_burst(input int sa, input int n, input int mode, input int abort_after);
    logic [DW:0]   exp_q[$];
    logic [DW+1:0] held = '0;
    bit            hold_chk = 0;
    bit            seen_done = 0;
    logic          rdy;
    int            cyc = 0;
    int            delivered = 0;
    int            last_pop = -1;
    for (int i = 0; i < n; i++) exp_q.push_back({1'(i == n - 1), mem[(sa + i) % DEPTH]});
    start      = 1'b1;
    start_addr = AW'(sa);
    num_words  = (AW + 1)'(n);
    out_ready  = pick_ready(mode, 0);
    while (!seen_done && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      start      = busy && ($urandom_range(0, 3) == 0);
      start_addr = AW'($urandom);
      num_words  = (AW + 1)'($urandom_range(0, 64));
      rdy        = pick_ready(mode, cyc);
      out_ready  = rdy;
      if (hold_chk) check_value("hold", {out_valid, out_last, out_data}, held);
      hold_chk = out_valid && !rdy;
      held     = {out_valid, out_last, out_data};
      if (mode == 0 && cyc <= n) check_value("mem_addr", mem_addr, (sa + cyc - 1) % DEPTH);
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check_value("extra_word", out_valid, 0);
        end else begin
          if (mode == 0) check_value("latency", cyc, 3 + delivered);
          check_value("word", {out_last, out_data}, exp_q.pop_front());
          delivered++;
          if (exp_q.size() == 0) last_pop = cyc;
        end
      end
      if (done) begin
        seen_done = 1;
        check_value("done_cyc", cyc, (n == 0) ? 1 : last_pop + 1);
        check_value("words_left", exp_q.size(), 0);
        check_value("busy_fin", busy, 1);
      end
      if (abort_after >= 0 && delivered == abort_after) begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          rst = 1'b0;
          check_value("abort_valid", out_valid, 0);
          check_value("abort_done", done, 0);
          check_value("abort_busy", busy, 0);
        end
        return;
      end
    end
    if (!seen_done) check_value("done_timeout", seen_done, 1);
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_value("idle_after", busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'($urandom);
    start_addr = AW'($urandom);
    num_words  = (AW + 1)'($urandom);
    out_ready  = 1'($urandom);
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 10);
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_valid", out_valid, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_addr", mem_addr, 0);
    check_value("rst_we", mem_we, 0);
    check_value("rst_data", {out_last, out_data}, 0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;

    run_burst(0, 4, 0, -1);
    run_burst(0, 4, 2, -1);
    run_burst(62, 4, 0, -1);
    run_burst(17, 0, 0, -1);
    run_burst(9, 64, 0, -1);

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int k = 0; k < 12; k++) begin
      run_burst($urandom_range(0, 63), $urandom_range(0, 64), (k % 2 == 0) ? 1 : 3, -1);
    end

    run_burst(20, 8, 0, 2);
    run_burst(40, 5, 0, -1);
    run_burst(63, 64, 3, -1);
    run_burst(1, 64, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side counterpart of the result-memory writer: sweeps a window of a single-port synchronous block memory (blk_mem, 1-cycle read latency) and streams the stored words out over a valid/ready interface.
- Sits between the result blk_mem (write-enable tied low on this port) and downstream consumers such as display or UART logic.
- A 2-entry buffer absorbs read latency under backpressure, so no word is lost or duplicated.

Parameters:
- ADDR_W, 6, memory address width; the memory holds 2^ADDR_W words.
- DATA_W, 8, memory word width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; ignored while busy.
- start_addr  in  ADDR_W  first address of the burst; sampled with start.
- num_words  in  ADDR_W+1  burst length, 0..2^ADDR_W; sampled with start.
- mem_addr  out  ADDR_W  registered address to blk_mem.
- mem_we  out  1  constant 0.
- mem_dout  in  DATA_W  blk_mem read data, valid 1 cycle after mem_addr.
- out_data  out  DATA_W  head word of the buffer.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_last  out  1  head word is the final word of the burst.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the burst completes.

Behaviour:
- Reset values: mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, buffer empty, pending read cleared, FSM=IDLE.
- FSM:
  - IDLE: on start with num_words>0, load addr=start_addr and remaining=num_words, then go to READ. On start with num_words=0, go to FIN.
  - READ: issue reads. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is pending, then go to FIN.
  - FIN: pulse done for one cycle, then return to IDLE.
- Issue rule: in READ, a read issues in cycle n when remaining>0 and occ + pend − pop < 2.
  - occ is the buffer count, pend is a read in flight, pop = out_valid & out_ready.
  - An issue presents addr on mem_addr, sets pend for the next cycle, then does addr++ and remaining−−.
- Capture: in the cycle where pend=1, mem_dout is pushed into the buffer at the end of that cycle, tagged last when it belongs to the final issued read.
- Address arithmetic: modulo 2^ADDR_W, so bursts wrap from all-ones to 0 silently.
- Latency: with start in cycle 0, mem_addr=start_addr in cycle 1, mem_dout valid in cycle 2, and out_valid=1 with word 0 in cycle 3.
- Throughput: one word per cycle while out_ready=1.
- Backpressure: while out_ready=0, out_data, out_last and out_valid hold stable. Issue stalls once occ+pend reaches 2. The buffer never overflows, and words are never dropped or reordered.
- Simultaneous push and pop on a full buffer is legal; the count stays unchanged.
- done pulses the cycle after the last-tagged word is accepted, or the cycle after start when num_words=0.
- busy is high in READ, DRAIN and FIN.
- start while busy: ignored, with no effect on the active burst.
- rst mid-burst: returns to reset values on the next edge and discards any pending read. No done pulse is produced.

Decomposition:
- Package mem_rd_pkg holds:
  - ADDR_W and DATA_W defaults.
  - State encoding constants IDLE/READ/DRAIN/FIN.
  - Buffer depth constant = 2.
- Sub-module rd_buf2: a 2-entry synchronous FIFO of {last, data}, with push/pop, count, head outputs, and the same clk/rst.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> out_valid=0, busy=0, done=0, mem_addr=0, mem_we=0.
- Basic burst: memory preloaded mem[i]=i+10; start, start_addr=0, num_words=4, out_ready=1 -> words 10,11,12,13 on cycles 3..6, out_last only with 13, done in cycle 7.
- Backpressure: same burst with out_ready=0 in cycles 4..6 -> word 11 held stable, never more than 2 reads outstanding, all 4 words delivered in order.
- Wrap: start_addr=62, num_words=4 -> mem_addr sequence 62,63,0,1, and the output matches memory contents.
- Zero/full length: num_words=0 -> done next cycle, no out_valid. num_words=64 -> 64 words, with the last one at address start_addr−1.
- Reset and restart: assert rst after 2 words of an 8-word burst -> no further out_valid, no done. A new start then runs cleanly from the new start_addr.
